// File: rtl/csr_file_m_if.sv
// CSR instruction access bus between the writeback stage (master) and csr_file_m (slave).
interface csr_file_m_if;
  logic        access;
  logic [11:0] addr;
  logic [1:0]  wtype;
  logic [31:0] woperand;
  logic [31:0] rdata;
  logic        illegal;

  modport master (output access, addr, wtype, woperand, input rdata, illegal);
  modport slave  (input access, addr, wtype, woperand, output rdata, illegal);
endinterface

// File: rtl/csr_file_m.sv
// Machine-mode CSR file for dtcore32: trap/mret sequencing, interrupts, performance counters.
// Define CSR_MTVEC_VECTORED_EN to enable vectored interrupt dispatch through mtvec[1:0].
module csr_file_m #(
  parameter int          NUM_HPM   = 4,
  parameter int          CNT_WIDTH = 64,
  parameter logic [31:0] HART_ID   = 32'd0,
  localparam int         HPM_W     = (NUM_HPM > 0) ? NUM_HPM : 1
) (
  input  logic             clk,
  input  logic             rst,
  csr_file_m_if.slave      csr,
  input  logic             retire,
  input  logic             trap_valid,
  input  logic             trap_is_irq,
  input  logic [30:0]      trap_cause,
  input  logic [31:0]      trap_pc,
  input  logic [31:0]      trap_tval,
  input  logic             mret,
  input  logic             irq_ext,
  input  logic             irq_timer,
  input  logic             irq_sw,
  input  logic [HPM_W-1:0] hpm_event,
  output logic [31:0]      trap_target,
  output logic [31:0]      mepc,
  output logic             irq_pending,
  output logic [30:0]      irq_cause
);

  // Counter slots are indexed by address low bits: 0 mcycle, 1 unused (time), 2 minstret, 3.. mhpm.
  localparam int          NCNT       = 3 + NUM_HPM;
  localparam logic [63:0] HPM_MASK64 = ((64'd1 << NUM_HPM) - 64'd1) << 3;
  localparam logic [31:0] INH_MASK   = 32'h5 | HPM_MASK64[31:0];
  localparam logic [31:0] MIE_MASK   = 32'h888;

  logic                 mstatus_mie, mstatus_mpie;
  logic [31:0]          mie_q, mscratch_q, mepc_q, mcause_q, mtval_q, minhibit_q;
  logic [29:0]          mtvec_base;
`ifdef CSR_MTVEC_VECTORED_EN
  logic                 mtvec_mode;
`endif
  logic                 mip_ext, mip_tim, mip_sw;
  logic [CNT_WIDTH-1:0] cnt_q [NCNT];
  logic [NCNT-1:0]      cnt_inc;

  logic [31:0]          rd, wdata, mstatus_rd, mip_rd, mtvec_rd;
  logic                 impl, cnt_region, cnt_impl, commit, cnt_wr;
  logic [4:0]           cnt_idx;
  logic [63:0]          cnt_ext, cnt_tmp;
  logic [CNT_WIDTH-1:0] cnt_sel, cnt_wval;
  logic                 pend_e, pend_t, pend_s;

  assign mstatus_rd = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
  assign mip_rd     = {20'd0, mip_ext, 3'd0, mip_tim, 3'd0, mip_sw, 3'd0};
`ifdef CSR_MTVEC_VECTORED_EN
  assign mtvec_rd   = {mtvec_base, 1'b0, mtvec_mode};
`else
  assign mtvec_rd   = {mtvec_base, 2'b00};
`endif

  always_comb begin
    cnt_idx    = csr.addr[4:0];
    cnt_region = (csr.addr[11:5] == 7'b1011000) || (csr.addr[11:5] == 7'b1011100);
    cnt_impl   = (cnt_idx == 5'd0) || (cnt_idx == 5'd2) ||
                 ((cnt_idx >= 5'd3) && (int'(cnt_idx) < NCNT));
    cnt_sel    = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (cnt_idx == 5'(i)) cnt_sel = cnt_q[i];
    end
    cnt_ext = '0;
    cnt_ext[CNT_WIDTH-1:0] = cnt_sel;
  end

  always_comb begin
    rd   = '0;
    impl = 1'b1;
    case (csr.addr)
      12'h300: rd = mstatus_rd;
      12'h304: rd = mie_q;
      12'h305: rd = mtvec_rd;
      12'h320: rd = minhibit_q;
      12'h340: rd = mscratch_q;
      12'h341: rd = mepc_q;
      12'h342: rd = mcause_q;
      12'h343: rd = mtval_q;
      12'h344: rd = mip_rd;
      12'hF14: rd = HART_ID;
      default: begin
        if (cnt_region && cnt_impl) rd = csr.addr[7] ? cnt_ext[63:32] : cnt_ext[31:0];
        else impl = 1'b0;
      end
    endcase
  end

  assign csr.rdata   = rd;
  assign csr.illegal = csr.access &&
                       (!impl || ((csr.wtype != 2'b00) && (csr.addr[11:10] == 2'b11)));

  always_comb begin
    case (csr.wtype)
      2'd2:    wdata = rd & ~csr.woperand;
      2'd3:    wdata = rd | csr.woperand;
      default: wdata = csr.woperand;
    endcase
  end

  // A write to one counter half rebuilds the full value with the other half held.
  always_comb begin
    cnt_tmp = cnt_ext;
    if (csr.addr[7]) cnt_tmp[63:32] = wdata;
    else             cnt_tmp[31:0]  = wdata;
    cnt_wval = cnt_tmp[CNT_WIDTH-1:0];
  end

  assign commit = csr.access && (csr.wtype != 2'b00) && !csr.illegal;
  assign cnt_wr = commit && !trap_valid && !mret && cnt_region;

  always_comb begin
    cnt_inc    = '0;
    cnt_inc[0] = !minhibit_q[0];
    cnt_inc[2] = retire && !minhibit_q[2];
    for (int k = 0; k < NUM_HPM; k++) begin
      cnt_inc[3+k] = hpm_event[k] && !minhibit_q[3+k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        if (cnt_wr && (cnt_idx == 5'(i))) cnt_q[i] <= cnt_wval;
        else if (cnt_inc[i])              cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mip_ext <= 1'b0;
      mip_tim <= 1'b0;
      mip_sw  <= 1'b0;
    end else begin
      mip_ext <= irq_ext;
      mip_tim <= irq_timer;
      mip_sw  <= irq_sw;
    end
  end

  // Trap entry outranks mret, which outranks a CSR write; the losing write is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_base   <= '0;
`ifdef CSR_MTVEC_VECTORED_EN
      mtvec_mode   <= 1'b0;
`endif
      minhibit_q   <= '0;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else if (trap_valid) begin
      mepc_q       <= {trap_pc[31:2], 2'b00};
      mcause_q     <= {trap_is_irq, trap_cause};
      mtval_q      <= trap_tval;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (commit) begin
      case (csr.addr)
        12'h300: begin
          mstatus_mie  <= wdata[3];
          mstatus_mpie <= wdata[7];
        end
        12'h304: mie_q <= wdata & MIE_MASK;
        12'h305: begin
          mtvec_base <= wdata[31:2];
`ifdef CSR_MTVEC_VECTORED_EN
          mtvec_mode <= (wdata[1:0] == 2'b01);
`endif
        end
        12'h320: minhibit_q <= wdata & INH_MASK;
        12'h340: mscratch_q <= wdata;
        12'h341: mepc_q     <= {wdata[31:2], 2'b00};
        12'h342: mcause_q   <= wdata;
        12'h343: mtval_q    <= wdata;
        default: ;
      endcase
    end
  end

  assign mepc        = mepc_q;
  assign pend_e      = mie_q[11] && mip_ext;
  assign pend_t      = mie_q[7]  && mip_tim;
  assign pend_s      = mie_q[3]  && mip_sw;
  assign irq_pending = mstatus_mie && (pend_e || pend_t || pend_s);

  always_comb begin
    irq_cause = '0;
    if (mstatus_mie) begin
      if (pend_e)      irq_cause = 31'd11;
      else if (pend_s) irq_cause = 31'd3;
      else if (pend_t) irq_cause = 31'd7;
    end
  end

`ifdef CSR_MTVEC_VECTORED_EN
  always_comb begin
    trap_target = {mtvec_base, 2'b00};
    if (mtvec_mode && trap_is_irq)
      trap_target = {mtvec_base, 2'b00} + {25'd0, trap_cause[4:0], 2'b00};
  end
`else
  assign trap_target = {mtvec_base, 2'b00};
`endif

endmodule

// File: tb/tb_csr_file_m.sv
// Directed scoreboard bench for csr_file_m built with NUM_HPM = 2 and CNT_WIDTH = 40.
module tb_csr_file_m;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

`ifdef CSR_MTVEC_VECTORED_EN
  localparam logic [31:0] MTVEC_RD   = 32'h0000_1001;
  localparam logic [31:0] IRQ_TARGET = 32'h0000_101C;
`else
  localparam logic [31:0] MTVEC_RD   = 32'h0000_1000;
  localparam logic [31:0] IRQ_TARGET = 32'h0000_1000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        retire, trap_valid, trap_is_irq, mret;
  logic [30:0] trap_cause;
  logic [31:0] trap_pc, trap_tval;
  logic        irq_ext, irq_timer, irq_sw;
  logic [1:0]  hpm_event;
  logic [31:0] trap_target, mepc;
  logic        irq_pending;
  logic [30:0] irq_cause;

  sb_item_t sb_q[$];
  int       n_assert = 0;
  int       n_fail   = 0;

  csr_file_m_if bus ();

  csr_file_m #(.NUM_HPM(2), .CNT_WIDTH(40), .HART_ID(32'd0)) dut (
    .clk         (clk),
    .rst         (rst),
    .csr         (bus.slave),
    .retire      (retire),
    .trap_valid  (trap_valid),
    .trap_is_irq (trap_is_irq),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .trap_tval   (trap_tval),
    .mret        (mret),
    .irq_ext     (irq_ext),
    .irq_timer   (irq_timer),
    .irq_sw      (irq_sw),
    .hpm_event   (hpm_event),
    .trap_target (trap_target),
    .mepc        (mepc),
    .irq_pending (irq_pending),
    .irq_cause   (irq_cause)
  );

  always #100 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] exp);
    sb_item_t item;
    item.tag = tag;
    item.exp = exp;
    sb_q.push_back(item);
  endtask

  task automatic check_output(input logic [31:0] obs);
    sb_item_t item;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_empty: observed %h with no expected value", obs);
    end else begin
      item = sb_q.pop_front();
      assert (obs === item.exp) else begin
        n_fail++;
        $error("[TB] FAIL %s: observed %h expected %h", item.tag, obs, item.exp);
      end
    end
  endtask

  task automatic check_read(input string tag, input logic [11:0] a, input logic [31:0] exp);
    bus.addr = a;
    expect_val(tag, exp);
    #1;
    check_output(bus.rdata);
  endtask

  task automatic csr_op(input logic [11:0] a, input logic [1:0] t, input logic [31:0] op);
    bus.access   = 1'b1;
    bus.addr     = a;
    bus.wtype    = t;
    bus.woperand = op;
    tick();
    bus.access   = 1'b0;
    bus.wtype    = 2'd0;
    bus.woperand = '0;
  endtask

  initial begin
    rst = 1'b1;
    bus.access = 1'b0; bus.addr = '0; bus.wtype = 2'd0; bus.woperand = '0;
    retire = 1'b0; trap_valid = 1'b0; trap_is_irq = 1'b0; mret = 1'b0;
    trap_cause = '0; trap_pc = '0; trap_tval = '0;
    irq_ext = 1'b0; irq_timer = 1'b0; irq_sw = 1'b0; hpm_event = 2'b00;
    tick();
    tick();

    $display("[TB] reset state");
    check_read("rst_mstatus", 12'h300, 32'h0000_1800);
    check_read("rst_mcycle", 12'hB00, 32'h0);
    expect_val("rst_pending", 32'h0); #1; check_output({31'd0, irq_pending});
    expect_val("rst_target", 32'h0);  #1; check_output(trap_target);
    expect_val("rst_illegal", 32'h0); #1; check_output({31'd0, bus.illegal});
    rst = 1'b0;
    tick();

    $display("[TB] counter wrap and width");
    csr_op(12'hB80, 2'd1, 32'h0);
    csr_op(12'hB00, 2'd1, 32'hFFFF_FFFF);
    tick();
    check_read("mcycleh_carry", 12'hB80, 32'h1);
    check_read("mcycle_carry", 12'hB00, 32'h0);
    csr_op(12'hB80, 2'd1, 32'hFFFF_FFFF);
    check_read("mcycleh_width40", 12'hB80, 32'h0000_00FF);
    check_read("mcycle_hold", 12'hB00, 32'h0);
    csr_op(12'hB00, 2'd1, 32'hFFFF_FFFF);
    tick();
    check_read("mcycleh_wrap", 12'hB80, 32'h0);
    check_read("mcycle_wrap", 12'hB00, 32'h0);
    csr_op(12'h320, 2'd1, 32'h1);
    tick(); tick(); tick();
    check_read("mcycle_inhibit", 12'hB00, 32'h1);
    csr_op(12'h320, 2'd1, 32'hFFFF_FFFF);
    check_read("minhibit_mask", 12'h320, 32'h0000_001D);
    csr_op(12'h320, 2'd1, 32'h1);

    $display("[TB] minstret and hpm counters");
    retire = 1'b1;
    tick(); tick(); tick();
    retire = 1'b0;
    check_read("minstret", 12'hB02, 32'h3);
    hpm_event = 2'b10;
    for (int i = 0; i < 5; i++) tick();
    hpm_event = 2'b00;
    check_read("mhpm4", 12'hB04, 32'h5);
    check_read("mhpm3", 12'hB03, 32'h0);
    check_read("mhpm4h", 12'hB84, 32'h0);
    bus.access = 1'b1;
    bus.addr = 12'hB05; expect_val("illegal_b05", 32'h1); #1; check_output({31'd0, bus.illegal});
    bus.addr = 12'hB01; expect_val("illegal_b01", 32'h1); #1; check_output({31'd0, bus.illegal});
    bus.addr = 12'hB04; expect_val("legal_b04", 32'h0);   #1; check_output({31'd0, bus.illegal});
    bus.addr = 12'hF14; bus.wtype = 2'd1; bus.woperand = 32'h1;
    expect_val("illegal_mhartid_wr", 32'h1); #1; check_output({31'd0, bus.illegal});
    tick();
    bus.access = 1'b0; bus.wtype = 2'd0; bus.woperand = '0;
    check_read("mhartid", 12'hF14, 32'h0);

    $display("[TB] interrupts");
    csr_op(12'h300, 2'd3, 32'h8);
    check_read("mstatus_mie", 12'h300, 32'h0000_1808);
    csr_op(12'h304, 2'd3, 32'h800);
    check_read("mie_mei", 12'h304, 32'h0000_0800);
    irq_ext = 1'b1;
    expect_val("pend_no_bypass", 32'h0); #1; check_output({31'd0, irq_pending});
    tick();
    expect_val("pend_ext", 32'h1);   #1; check_output({31'd0, irq_pending});
    expect_val("cause_ext", 32'd11); #1; check_output({1'b0, irq_cause});
    irq_timer = 1'b1;
    csr_op(12'h304, 2'd3, 32'h80);
    check_read("mip_ext_tim", 12'h344, 32'h0000_0880);
    expect_val("cause_ext_over_tim", 32'd11); #1; check_output({1'b0, irq_cause});
    irq_ext = 1'b0;
    irq_sw  = 1'b1;
    csr_op(12'h304, 2'd3, 32'h8);
    expect_val("cause_sw_over_tim", 32'd3); #1; check_output({1'b0, irq_cause});
    irq_sw = 1'b0;
    tick();
    expect_val("cause_tim", 32'd7); #1; check_output({1'b0, irq_cause});
    csr_op(12'h304, 2'd1, 32'hFFFF_FFFF);
    check_read("mie_mask", 12'h304, 32'h0000_0888);

    $display("[TB] trap and mret");
    csr_op(12'h305, 2'd1, 32'h0000_1001);
    check_read("mtvec", 12'h305, MTVEC_RD);
    trap_valid = 1'b1; trap_is_irq = 1'b1; trap_cause = 31'd7;
    trap_pc = 32'h8000_0007; trap_tval = 32'hDEAD_BEEF;
    bus.access = 1'b1; bus.addr = 12'h340; bus.wtype = 2'd1; bus.woperand = 32'h55;
    expect_val("target_irq7", IRQ_TARGET); #1; check_output(trap_target);
    tick();
    trap_valid = 1'b0;
    bus.access = 1'b0; bus.wtype = 2'd0; bus.woperand = '0;
    check_read("trap_mstatus", 12'h300, 32'h0000_1880);
    check_read("trap_mepc", 12'h341, 32'h8000_0004);
    check_read("trap_mcause", 12'h342, 32'h8000_0007);
    check_read("trap_mtval", 12'h343, 32'hDEAD_BEEF);
    check_read("trap_mscratch", 12'h340, 32'h0);
    expect_val("mepc_out", 32'h8000_0004); #1; check_output(mepc);
    expect_val("trap_pend", 32'h0);        #1; check_output({31'd0, irq_pending});
    trap_is_irq = 1'b0; trap_cause = 31'd2;
    expect_val("target_exc2", 32'h0000_1000); #1; check_output(trap_target);
    mret = 1'b1;
    csr_op(12'h300, 2'd1, 32'h0);
    mret = 1'b0;
    check_read("mret_mstatus", 12'h300, 32'h0000_1888);
    expect_val("mret_cause", 32'd7); #1; check_output({1'b0, irq_cause});

    $display("[TB] write types");
    csr_op(12'h340, 2'd1, 32'hA5A5_A5A5);
    check_read("mscratch_raw", 12'h340, 32'hA5A5_A5A5);
    csr_op(12'h340, 2'd2, 32'h0000_00F0);
    check_read("mscratch_clr", 12'h340, 32'hA5A5_A505);
    csr_op(12'h340, 2'd3, 32'h0F00_0000);
    check_read("mscratch_set", 12'h340, 32'hAFA5_A505);
    csr_op(12'h341, 2'd1, 32'h0000_0123);
    check_read("mepc_align", 12'h341, 32'h0000_0120);

    $display("[TB] asynchronous reset mid-run");
    csr_op(12'hB00, 2'd1, 32'h0000_1234);
    tick();
    check_read("mcycle_frozen", 12'hB00, 32'h0000_1234);
    #5;
    rst = 1'b1;
    check_read("arst_mcycle", 12'hB00, 32'h0);
    check_read("arst_mstatus", 12'h300, 32'h0000_1800);
    check_read("arst_mscratch", 12'h340, 32'h0);
    expect_val("arst_mepc", 32'h0);    #1; check_output(mepc);
    expect_val("arst_target", 32'h0);  #1; check_output(trap_target);
    expect_val("arst_pending", 32'h0); #1; check_output({31'd0, irq_pending});
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
